// File: rtl/mmu_pkg.sv
// Shared MMU package: data-cache line type plus line-controller state and
// arbitration constants.
package mmu_pkg;

   typedef logic [256:0] DCacheLine;

   typedef enum logic {
      SWEEP,
      RUN
   } dcache_ctrl_state_e;

   localparam int unsigned DCACHE_STARVE_LIM = 3;

endpackage

// File: rtl/sram_257x1024_1r1w.sv
// Simple dual-port line RAM: one synchronous write port and one registered
// read port. A read of the address being written returns the old contents.
module sram_257x1024_1r1w
   import mmu_pkg::*;
#(
   parameter int unsigned LINES = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk,
   input  logic          wr,
   input  logic [AW-1:0] wadr,
   input  logic [AW-1:0] radr,
   input  DCacheLine     i,
   output DCacheLine     o
);

   DCacheLine mem [LINES];

   // Write port and registered read port share the clock edge.
   always_ff @(posedge clk) begin
      if (wr) mem[wadr] <= i;
      o <= mem[radr];
   end

endmodule

// File: rtl/dcache_line_ctrl.sv
// Data-cache line RAM controller: invalidate sweep after reset or clr_req,
// fill/store write-port arbitration with store starvation protection,
// registered reads. Optional same-cycle write->read forwarding is enabled
// with the DCACHE_FWD_EN macro.
module dcache_line_ctrl
   import mmu_pkg::*;
#(
   parameter int unsigned LINES      = 1024,
   parameter int unsigned AW         = 10,
   parameter int unsigned STARVE_LIM = DCACHE_STARVE_LIM
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   input  logic          fill_req,
   input  logic [AW-1:0] fill_adr,
   input  DCacheLine     fill_dat,
   output logic          fill_ack,
   input  logic          st_req,
   input  logic [AW-1:0] st_adr,
   input  DCacheLine     st_dat,
   output logic          st_ack,
   input  logic [AW-1:0] rd_adr,
   output DCacheLine     rd_dat,
   output logic          rd_vld
);

   localparam logic [AW-1:0] LAST_LINE = AW'(LINES - 1);
   localparam logic [2:0]    LIM3      = 3'(STARVE_LIM);

   dcache_ctrl_state_e state_q, state_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic [2:0]         starve_q, starve_d;
   logic               rd_vld_q, rd_vld_d;

   logic               ram_wr;
   logic [AW-1:0]      ram_wadr;
   DCacheLine          ram_wdat;
   DCacheLine          ram_rdat;

   // Sweep sequencing, write-port arbitration and starvation counting.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      fill_ack = 1'b0;
      st_ack   = 1'b0;
      ram_wr   = 1'b0;
      ram_wadr = cnt_q;
      ram_wdat = '0;
      busy     = (state_q == SWEEP);
      rd_vld_d = (state_q == RUN);
      case (state_q)
         SWEEP: begin
            ram_wr = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_LINE) state_d = RUN;
         end
         RUN: begin
            // The clr_req cycle issues no write so the sweep owns the port
            // from the very next edge.
            if (clr_req) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end else if (st_req && (starve_q >= LIM3)) begin
               st_ack   = 1'b1;
               ram_wr   = 1'b1;
               ram_wadr = st_adr;
               ram_wdat = st_dat;
            end else if (fill_req) begin
               fill_ack = 1'b1;
               ram_wr   = 1'b1;
               ram_wadr = fill_adr;
               ram_wdat = fill_dat;
            end else if (st_req) begin
               st_ack   = 1'b1;
               ram_wr   = 1'b1;
               ram_wadr = st_adr;
               ram_wdat = st_dat;
            end
            if (st_ack) starve_d = '0;
            else if (fill_ack && st_req && (starve_q != 3'd7)) starve_d = starve_q + 3'd1;
         end
         default: state_d = SWEEP;
      endcase
      // Nothing reaches the RAM while reset is held.
      if (rst) ram_wr = 1'b0;
   end

   // Controller state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SWEEP;
         cnt_q    <= '0;
         starve_q <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign rd_vld = rd_vld_q;

   sram_257x1024_1r1w #(
      .LINES (LINES),
      .AW    (AW)
   ) u_ram (
      .clk  (clk),
      .wr   (ram_wr),
      .wadr (ram_wadr),
      .radr (rd_adr),
      .i    (ram_wdat),
      .o    (ram_rdat)
   );

`ifdef DCACHE_FWD_EN
   logic      fwd_hit_q, fwd_hit_d;
   DCacheLine fwd_dat_q, fwd_dat_d;

   // Capture a write that targets the line being read this cycle.
   always_comb begin
      fwd_hit_d = ram_wr && (ram_wadr == rd_adr);
      fwd_dat_d = ram_wdat;
   end

   // Forwarding registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fwd_hit_q <= 1'b0;
         fwd_dat_q <= '0;
      end else begin
         fwd_hit_q <= fwd_hit_d;
         fwd_dat_q <= fwd_dat_d;
      end
   end

   // Read data: forwarded line on a collision, RAM output otherwise.
   always_comb begin
      rd_dat = '0;
      if (rd_vld_q) rd_dat = fwd_hit_q ? fwd_dat_q : ram_rdat;
   end
`else
   // Read data straight from the RAM, held at zero while not valid.
   always_comb begin
      rd_dat = '0;
      if (rd_vld_q) rd_dat = ram_rdat;
   end
`endif

endmodule
